hamming_window: RTL

Frame windowing stage that sits directly downstream of the sliding window buffer in the MFCC front end. It waits for the buffer to announce a ready frame, pops exactly `FRAME_LEN` samples through the buffer's read interface, and multiplies each sample by a Hamming coefficient in Q1.15 with rounding and saturation. Windowed samples go out on a valid/ready stream toward the FFT stage. When a frame is finished, the block requests the next hop from the buffer through a start-move handshake.

---
 rtl/mfcc_pkg.sv | 38 +++
 rtl/hamming_rom.sv | 34 +++
 rtl/hamming_window.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mfcc_pkg.sv
// mfcc_pkg
// Shared definitions for the MFCC front end windowing stage.
//   win_state_t       : windowing FSM state encoding
//   Q15_ONE/Q15_HALF  : Q1.15 scale and rounding constant
//   DEFAULT_FRAME_LEN : samples per frame (equals sliding buffer size)
//   DEFAULT_HOP_SIZE  : samples the buffer slides per start-move request
//   hamming_coef()    : elaboration-time Hamming coefficient generator
package mfcc_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    STREAM     = 2'd1,
    DRAIN      = 2'd2,
    MOVE       = 2'd3
  } win_state_t;

  localparam int Q15_ONE           = 32768;
  localparam int Q15_HALF          = 16384;
  localparam int DEFAULT_FRAME_LEN = 306;
  localparam int DEFAULT_HOP_SIZE  = 123;

  localparam real PI = 3.14159265358979323846;

  // round(Q15_ONE * (0.54 - 0.46*cos(2*pi*n/(frame_len-1)))), clamped.
  // The value is always positive, so adding one half and truncating rounds
  // to nearest.
  function automatic int hamming_coef(input int n, input int frame_len,
                                      input int coef_max);
    real v;
    int  c;
    v = real'(Q15_ONE) *
        (0.54 - 0.46 * $cos(2.0 * PI * real'(n) / real'(frame_len - 1)));
    c = $rtoi(v + 0.5);
    if (c > coef_max) c = coef_max;
    return c;
  endfunction

endpackage

// File: rtl/hamming_rom.sv
// hamming_rom
// Combinational Hamming coefficient lookup. The table is computed while the
// design elaborates, so it follows FRAME_LEN and COEF_WIDTH automatically.
// Ports:
//   idx  : in,  IDX_WIDTH  : sample index within the frame
//   coef : out, COEF_WIDTH : unsigned Q1.15 coefficient (0 for idx out of range)
module hamming_rom
  import mfcc_pkg::*;
#(
  parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int COEF_WIDTH = 16,
  parameter int IDX_WIDTH  = $clog2(FRAME_LEN)
) (
  input  logic [IDX_WIDTH-1:0]  idx,
  output logic [COEF_WIDTH-1:0] coef
);

  // Largest representable coefficient just below 1.0 in Q1.15.
  localparam int COEF_MAX = (1 << (COEF_WIDTH - 1)) - 1;

  logic [COEF_WIDTH-1:0] table_w [FRAME_LEN];

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_tab
    localparam logic [COEF_WIDTH-1:0] C =
      COEF_WIDTH'(hamming_coef(g, FRAME_LEN, COEF_MAX));
    assign table_w[g] = C;
  end

  always_comb begin
    coef = '0;
    if (int'(idx) < FRAME_LEN) coef = table_w[idx];
  end

endmodule

// File: rtl/hamming_window.sv
// hamming_window
// Windowing stage between the sliding window buffer and the FFT. After the
// buffer announces a frame it pops FRAME_LEN samples, multiplies each by a
// Q1.15 Hamming coefficient (round half up, saturate) and streams the result
// out. When the last sample is accepted it asks the buffer to slide one hop.
//
// Optional feature: define HAMMING_BYPASS_EN to add bypass_i, which passes
// samples through unwindowed (sampled per pop, same handshake and latency).
//
// Ports:
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   frame_ready_i  : buffer pulse, a full frame is ready to be read
//   buf_valid_i    : buffer read sample valid
//   buf_data_i     : buffer read data (combinational from its read pointer)
//   buf_rd_en_o    : pop strobe, buffer advances on buf_rd_en_o && buf_valid_i
//   start_move_o   : request the buffer to slide by one hop
//   bypass_i       : (HAMMING_BYPASS_EN only) pass sample through unmodified
//   data_o/valid_o/ready_i/last_o : windowed output stream
//   frame_cnt_o    : completed frames, wrapping
//   state_o        : debug view of the FSM state (win_state_t encoding)
//
// Handshake: an output beat transfers on a cycle where valid_o && ready_i.
// data_o and last_o are stable while valid_o && !ready_i, and valid_o never
// drops without a transfer. On the input side a sample is consumed on a cycle
// where buf_rd_en_o && buf_valid_i.
module hamming_window
  import mfcc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAME_LEN  = DEFAULT_FRAME_LEN,
  parameter int COEF_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_ready_i,
  input  logic                 buf_valid_i,
  input  logic [WIDTH-1:0]     buf_data_i,
  output logic                 buf_rd_en_o,
  output logic                 start_move_o,
`ifdef HAMMING_BYPASS_EN
  input  logic                 bypass_i,
`endif
  output logic [WIDTH-1:0]     data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o,
  output logic [1:0]           state_o
);

  localparam int IDX_WIDTH  = $clog2(FRAME_LEN);
  localparam int PROD_WIDTH = WIDTH + COEF_WIDTH + 1;
  localparam int FRAC_BITS  = 15;

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(FRAME_LEN - 1);

  localparam logic [1:0] ST_WAIT_FRAME = WAIT_FRAME;
  localparam logic [1:0] ST_STREAM     = STREAM;
  localparam logic [1:0] ST_DRAIN      = DRAIN;
  localparam logic [1:0] ST_MOVE       = MOVE;

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [WIDTH-1:0]      data_q;
  logic                  valid_q;
  logic                  last_q;
  logic [CNT_WIDTH-1:0]  frame_cnt_q;

  logic                  pop;
  logic                  restart;
  logic                  frame_done;
  logic                  start_move;
  logic [COEF_WIDTH-1:0] coef;

  logic signed [PROD_WIDTH-1:0] prod;
  logic signed [PROD_WIDTH-1:0] prod_rnd;
  logic signed [PROD_WIDTH-1:0] shifted;
  logic [WIDTH-1:0]             win_sample;
  logic [WIDTH-1:0]             out_sample;

  // ---------------------------------------------------------------------------
  // Coefficient lookup
  // ---------------------------------------------------------------------------
  hamming_rom #(
    .FRAME_LEN  (FRAME_LEN),
    .COEF_WIDTH (COEF_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_rom (
    .idx  (idx_q),
    .coef (coef)
  );

  // ---------------------------------------------------------------------------
  // Datapath: signed sample times unsigned coefficient (zero-extended so it
  // stays positive), round half up, arithmetic shift back to sample scale.
  // ---------------------------------------------------------------------------
  always_comb begin
    prod     = PROD_WIDTH'($signed(buf_data_i)) *
               PROD_WIDTH'($signed({1'b0, coef}));
    prod_rnd = prod + PROD_WIDTH'(Q15_HALF);
    shifted  = prod_rnd >>> FRAC_BITS;

    // In range when every bit above the sample sign bit copies it.
    if ((shifted[PROD_WIDTH-1:WIDTH-1] == '0) ||
        (shifted[PROD_WIDTH-1:WIDTH-1] == '1)) begin
      win_sample = shifted[WIDTH-1:0];
    end else if (shifted[PROD_WIDTH-1]) begin
      win_sample = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      win_sample = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

`ifdef HAMMING_BYPASS_EN
  assign out_sample = bypass_i ? buf_data_i : win_sample;
`else
  assign out_sample = win_sample;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    start_move = 1'b0;
    unique case (state_q)
      ST_WAIT_FRAME: begin
        if (frame_ready_i) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        // Pop only when the output register is free or being emptied now.
        pop = buf_valid_i && (!valid_q || ready_i);
        if (pop && (idx_q == IDX_LAST)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (valid_q && ready_i && last_q) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        // Drops combinationally in the cycle the buffer answers.
        start_move = !frame_ready_i;
        if (frame_ready_i) state_d = ST_STREAM;
      end
      default: state_d = ST_WAIT_FRAME;
    endcase
  end

  assign restart    = ((state_q == ST_WAIT_FRAME) || (state_q == ST_MOVE)) &&
                      frame_ready_i;
  assign frame_done = (state_q == ST_DRAIN) && valid_q && ready_i && last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT_FRAME;
      idx_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;

      // The last pop leaves idx at FRAME_LEN-1; the state change to DRAIN
      // ends the frame instead of a wrap.
      if (restart) begin
        idx_q <= '0;
      end else if (pop && (idx_q != IDX_LAST)) begin
        idx_q <= idx_q + 1'b1;
      end

      if (pop) begin
        data_q  <= out_sample;
        valid_q <= 1'b1;
        last_q  <= (idx_q == IDX_LAST);
      end else if (ready_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end

      if (frame_done) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign buf_rd_en_o  = pop;
  assign start_move_o = start_move;
  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign last_o       = last_q;
  assign frame_cnt_o  = frame_cnt_q;
  assign state_o      = state_q;

endmodule
